// File: rtl/my_ep_tx_cpl_engine_pkg.sv
// Shared types, header constants and header-field helpers for the completion
// transmit engine.
package my_ep_tx_cpl_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_HDR2,
    ST_DATA,
    ST_DONE
  } state_t;

  localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
  localparam logic [1:0] FMT_3DW_DATA   = 2'b10;
  localparam logic [4:0] TYPE_CPL       = 5'b01010;

  function automatic logic [31:0] make_hdr0(input logic with_data, input logic [2:0] tc,
                                            input logic td, input logic ep,
                                            input logic [1:0] attr, input logic [9:0] len);
    return {1'b0, (with_data ? FMT_3DW_DATA : FMT_3DW_NODATA), TYPE_CPL,
            1'b0, tc, 4'b0000, td, ep, attr, 2'b00, (with_data ? len : 10'd0)};
  endfunction

  // A 4096-byte completion wraps to 0 in the 12-bit field, as the header encodes it.
  function automatic logic [11:0] calc_byte_count(input logic with_data, input logic [9:0] len,
                                                  input logic [3:0] fbe, input logic [3:0] lbe);
    logic [12:0] total;
    logic [2:0]  tz;
    logic [2:0]  lz;
    if (!with_data) return 12'd4;
    if (len == 10'd1) begin
      casez (fbe)
        4'b1??1:                  return 12'd4;
        4'b01?1, 4'b1?10:         return 12'd3;
        4'b0011, 4'b0110, 4'b1100: return 12'd2;
        default:                  return 12'd1;
      endcase
    end
    casez (fbe)
      4'b???1: tz = 3'd0;
      4'b??10: tz = 3'd1;
      4'b?100: tz = 3'd2;
      4'b1000: tz = 3'd3;
      default: tz = 3'd4;
    endcase
    casez (lbe)
      4'b1???: lz = 3'd0;
      4'b01??: lz = 3'd1;
      4'b001?: lz = 3'd2;
      4'b0001: lz = 3'd3;
      default: lz = 3'd4;
    endcase
    total = {(len == 10'd0), len, 2'b00} - 13'(tz) - 13'(lz);
    return total[11:0];
  endfunction

  function automatic logic [6:0] calc_lower_addr(input logic [12:0] addr, input logic [3:0] fbe);
    logic [1:0] low;
    casez (fbe)
      4'b??10: low = 2'd1;
      4'b?100: low = 2'd2;
      4'b1000: low = 2'd3;
      default: low = 2'd0;
    endcase
    return {addr[6:2], low};
  endfunction

endpackage

// File: rtl/my_ep_tx_cpl_engine_pf_fifo.sv
// Payload prefetch FIFO: DEPTH x 32 synchronous FIFO with occupancy count.
module my_ep_tx_pf_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [31:0]              push_data,
  input  logic                     pop,
  output logic [31:0]              pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);

endmodule

// File: rtl/my_ep_tx_cpl_engine.sv
// Completion TLP transmit engine: captures a request, prefetches CplD payload
// from endpoint memory and serialises the 3DW completion onto the TRN bus.
module my_ep_tx_cpl_engine #(
  parameter int MEM_RD_LAT = 2,
  parameter int PF_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_compl_i,
  input  logic        req_compl_with_data_i,
  input  logic [2:0]  req_tc_i,
  input  logic        req_td_i,
  input  logic        req_ep_i,
  input  logic [1:0]  req_attr_i,
  input  logic [9:0]  req_len_i,
  input  logic [15:0] req_rid_i,
  input  logic [7:0]  req_tag_i,
  input  logic [7:0]  req_be_i,
  input  logic [12:0] req_addr_i,
  output logic        compl_done_o,
  input  logic [15:0] cfg_completer_id_i,
  output logic [10:0] rd_addr_o,
  output logic [3:0]  rd_be_o,
  input  logic [31:0] rd_data_i,
  output logic [31:0] trn_td_o,
  output logic        trn_tsof_n_o,
  output logic        trn_teof_n_o,
  output logic        trn_tsrc_rdy_n_o,
  output logic        trn_tsrc_dsc_n_o,
  input  logic        trn_tdst_rdy_n_i
);
  import my_ep_tx_cpl_engine_pkg::*;

  localparam int CW = $clog2(PF_DEPTH) + 1;

  state_t state, next_state;

  logic            with_data_q;
  logic [31:0]     hdr1_q, hdr2_q;
  logic [3:0]      lbe_q;
  logic [10:0]     load_left, reads_left;
  logic            rd_issue_q;
  logic [MEM_RD_LAT-1:0] lat_sr;
  logic [CW-1:0]   outstanding;

  logic            fifo_push, fifo_pop, fifo_empty;
  logic [31:0]     fifo_dout;
  logic [CW-1:0]   fifo_count;

  logic            accept, capture, rd_push, dw_avail, load_dw;
  logic            issue_first, can_issue;
  logic [31:0]     dw_next, n_td;
  logic            n_sof, n_eof, n_rdy, n_done;
  logic [10:0]     len_dw;

  assign len_dw      = {(req_len_i == 10'd0), req_len_i};
  assign accept      = !trn_tsrc_rdy_n_o && !trn_tdst_rdy_n_i;
  assign capture     = (state == ST_IDLE) && req_compl_i;
  assign rd_push     = lat_sr[MEM_RD_LAT-1];
  // Read data arriving into an empty FIFO can be loaded straight onto the bus.
  assign dw_avail    = !fifo_empty || rd_push;
  assign dw_next     = fifo_empty ? rd_data_i : fifo_dout;
  assign issue_first = capture && req_compl_with_data_i;
  assign can_issue   = (state != ST_IDLE) && (state != ST_DONE) && (reads_left != 11'd0) &&
                       (int'(outstanding) + int'(fifo_count) < PF_DEPTH);
  assign fifo_pop    = load_dw && !fifo_empty;
  assign fifo_push   = rd_push && !(load_dw && fifo_empty);
  assign trn_tsrc_dsc_n_o = 1'b1;

  my_ep_tx_pf_fifo #(.DEPTH(PF_DEPTH)) u_pf_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (rd_data_i),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    n_td       = trn_td_o;
    n_sof      = trn_tsof_n_o;
    n_eof      = trn_teof_n_o;
    n_rdy      = trn_tsrc_rdy_n_o;
    n_done     = 1'b0;
    load_dw    = 1'b0;
    case (state)
      ST_IDLE: if (req_compl_i) begin
        next_state = ST_HDR0;
        n_td  = make_hdr0(req_compl_with_data_i, req_tc_i, req_td_i, req_ep_i, req_attr_i, req_len_i);
        n_sof = 1'b0;
        n_eof = 1'b1;
        n_rdy = 1'b0;
      end
      ST_HDR0: if (accept) begin
        next_state = ST_HDR1;
        n_td  = hdr1_q;
        n_sof = 1'b1;
      end
      ST_HDR1: if (accept) begin
        next_state = ST_HDR2;
        n_td  = hdr2_q;
        n_eof = with_data_q;
      end
      ST_HDR2: if (accept) begin
        if (with_data_q) begin
          next_state = ST_DATA;
          n_eof = 1'b1;
          n_rdy = 1'b1;
          if (dw_avail) begin
            load_dw = 1'b1;
            n_td  = dw_next;
            n_rdy = 1'b0;
            n_eof = (load_left != 11'd1);
          end
        end else begin
          next_state = ST_DONE;
          n_td   = '0;
          n_eof  = 1'b1;
          n_rdy  = 1'b1;
          n_done = 1'b1;
        end
      end
      ST_DATA: begin
        if (accept && !trn_teof_n_o) begin
          next_state = ST_DONE;
          n_td   = '0;
          n_eof  = 1'b1;
          n_rdy  = 1'b1;
          n_done = 1'b1;
        end else if (trn_tsrc_rdy_n_o || accept) begin
          n_rdy = 1'b1;
          if (dw_avail) begin
            load_dw = 1'b1;
            n_td  = dw_next;
            n_rdy = 1'b0;
            n_eof = (load_left != 11'd1);
          end
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Header words 1 and 2 are built at capture; only HDR0 goes out directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trn_td_o         <= '0;
      trn_tsof_n_o     <= 1'b1;
      trn_teof_n_o     <= 1'b1;
      trn_tsrc_rdy_n_o <= 1'b1;
      compl_done_o     <= 1'b0;
      rd_addr_o        <= '0;
      rd_be_o          <= '0;
      rd_issue_q       <= 1'b0;
      lat_sr           <= '0;
      outstanding      <= '0;
      with_data_q      <= 1'b0;
      hdr1_q           <= '0;
      hdr2_q           <= '0;
      lbe_q            <= '0;
      load_left        <= '0;
      reads_left       <= '0;
    end else begin
      trn_td_o         <= n_td;
      trn_tsof_n_o     <= n_sof;
      trn_teof_n_o     <= n_eof;
      trn_tsrc_rdy_n_o <= n_rdy;
      compl_done_o     <= n_done;
      if (capture) begin
        with_data_q <= req_compl_with_data_i;
        hdr1_q      <= {cfg_completer_id_i, 3'b000, 1'b0,
                        calc_byte_count(req_compl_with_data_i, req_len_i, req_be_i[3:0], req_be_i[7:4])};
        hdr2_q      <= {req_rid_i, req_tag_i, 1'b0, calc_lower_addr(req_addr_i, req_be_i[3:0])};
        lbe_q       <= req_be_i[7:4];
        load_left   <= len_dw;
      end else if (load_dw) begin
        load_left <= load_left - 11'd1;
      end
      if (issue_first) begin
        rd_issue_q <= 1'b1;
        rd_addr_o  <= req_addr_i[12:2];
        rd_be_o    <= req_be_i[3:0];
        reads_left <= len_dw - 11'd1;
      end else if (can_issue) begin
        rd_issue_q <= 1'b1;
        rd_addr_o  <= rd_addr_o + 11'd1;
        rd_be_o    <= (reads_left == 11'd1) ? lbe_q : 4'hF;
        reads_left <= reads_left - 11'd1;
      end else begin
        rd_issue_q <= 1'b0;
      end
      lat_sr[0] <= rd_issue_q;
      for (int i = 1; i < MEM_RD_LAT; i++) lat_sr[i] <= lat_sr[i-1];
      outstanding <= outstanding + CW'(issue_first || can_issue) - CW'(rd_push);
    end
  end

endmodule

// File: tb/tb_my_ep_tx_cpl_engine.sv
// Directed self-checking bench for the completion transmit engine.
module tb_my_ep_tx_cpl_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_compl_i, req_compl_with_data_i, req_td_i, req_ep_i;
  logic [2:0]  req_tc_i;
  logic [1:0]  req_attr_i;
  logic [9:0]  req_len_i;
  logic [15:0] req_rid_i, cfg_completer_id_i;
  logic [7:0]  req_tag_i, req_be_i;
  logic [12:0] req_addr_i;
  logic        compl_done_o;
  logic [10:0] rd_addr_o;
  logic [3:0]  rd_be_o;
  logic [31:0] rd_data_i, trn_td_o;
  logic        trn_tsof_n_o, trn_teof_n_o, trn_tsrc_rdy_n_o, trn_tsrc_dsc_n_o, trn_tdst_rdy_n_i;

  always #5 clk = ~clk;

  my_ep_tx_cpl_engine dut (
    .clk(clk), .rst_n(rst_n), .req_compl_i(req_compl_i),
    .req_compl_with_data_i(req_compl_with_data_i), .req_tc_i(req_tc_i), .req_td_i(req_td_i),
    .req_ep_i(req_ep_i), .req_attr_i(req_attr_i), .req_len_i(req_len_i), .req_rid_i(req_rid_i),
    .req_tag_i(req_tag_i), .req_be_i(req_be_i), .req_addr_i(req_addr_i),
    .compl_done_o(compl_done_o), .cfg_completer_id_i(cfg_completer_id_i),
    .rd_addr_o(rd_addr_o), .rd_be_o(rd_be_o), .rd_data_i(rd_data_i), .trn_td_o(trn_td_o),
    .trn_tsof_n_o(trn_tsof_n_o), .trn_teof_n_o(trn_teof_n_o), .trn_tsrc_rdy_n_o(trn_tsrc_rdy_n_o),
    .trn_tsrc_dsc_n_o(trn_tsrc_dsc_n_o), .trn_tdst_rdy_n_i(trn_tdst_rdy_n_i)
  );

  // Endpoint memory model with a two-cycle read latency.
  logic [31:0] mem [0:2047];
  logic [10:0] a1, a2;
  always @(posedge clk) begin
    a1 <= rd_addr_o;
    a2 <= a1;
  end
  assign rd_data_i = mem[a2];

  int total = 0;
  int bad = 0;
  logic [31:0] exp_td [0:15];
  logic [31:0] got_td [0:15];
  logic [31:0] sof_mask, eof_mask;
  int n_got, cyc_used, stab_err, done_seen, finished, extra;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic wd, input logic [9:0] len, input logic [7:0] be,
                         input logic [12:0] addr, input logic [7:0] tag, input logic [2:0] tc,
                         input logic [1:0] attr, input logic td);
    @(negedge clk);
    req_compl_with_data_i = wd;
    req_len_i  = len;
    req_be_i   = be;
    req_addr_i = addr;
    req_tag_i  = tag;
    req_tc_i   = tc;
    req_attr_i = attr;
    req_td_i   = td;
    req_compl_i = 1'b1;
    @(negedge clk);
    req_compl_i = 1'b0;
  endtask

  task automatic collect(input bit toggle, input bit inject);
    logic        prev_stall;
    logic [34:0] prev_out;
    n_got = 0; sof_mask = '0; eof_mask = '0; stab_err = 0; done_seen = 0; finished = 0;
    prev_stall = 1'b0; prev_out = '0; cyc_used = 0;
    for (int cyc = 0; cyc < 200 && finished == 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      req_compl_i = inject && (cyc == 5);
      trn_tdst_rdy_n_i = toggle && (cyc % 2 == 0);
      if (prev_stall && ({trn_td_o, trn_tsof_n_o, trn_teof_n_o, trn_tsrc_rdy_n_o} != prev_out))
        stab_err++;
      if (compl_done_o) done_seen++;
      prev_stall = !trn_tsrc_rdy_n_o && trn_tdst_rdy_n_i;
      prev_out   = {trn_td_o, trn_tsof_n_o, trn_teof_n_o, trn_tsrc_rdy_n_o};
      if (!trn_tsrc_rdy_n_o && !trn_tdst_rdy_n_i) begin
        if (n_got < 16) begin
          got_td[n_got]   = trn_td_o;
          sof_mask[n_got] = !trn_tsof_n_o;
          eof_mask[n_got] = !trn_teof_n_o;
        end
        n_got++;
        if (!trn_teof_n_o) finished = 1;
      end
      cyc_used = cyc + 1;
    end
    req_compl_i = 1'b0;
    trn_tdst_rdy_n_i = 1'b0;
    check("timeout", 32'(finished), 32'd1);
  endtask

  task automatic verify(input string name, input int n);
    check($sformatf("%s_nbeats", name), 32'(n_got), 32'(n));
    for (int i = 0; i < n && i < 16; i++)
      check($sformatf("%s_beat%0d", name, i), got_td[i], exp_td[i]);
    check($sformatf("%s_sof", name), sof_mask, 32'd1);
    check($sformatf("%s_eof", name), eof_mask, 32'd1 << (n - 1));
    check($sformatf("%s_stable", name), 32'(stab_err), 32'd0);
    check($sformatf("%s_early_done", name), 32'(done_seen), 32'd0);
    @(negedge clk);
    check($sformatf("%s_done_pulse", name), 32'(compl_done_o), 32'd1);
    @(negedge clk);
    check($sformatf("%s_done_clear", name), 32'(compl_done_o), 32'd0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_src_rdy"}, 32'(trn_tsrc_rdy_n_o), 32'd1);
    check({name, "_sof"},     32'(trn_tsof_n_o), 32'd1);
    check({name, "_eof"},     32'(trn_teof_n_o), 32'd1);
    check({name, "_dsc"},     32'(trn_tsrc_dsc_n_o), 32'd1);
    check({name, "_td"},      trn_td_o, 32'd0);
    check({name, "_done"},    32'(compl_done_o), 32'd0);
    check({name, "_rd_addr"}, 32'(rd_addr_o), 32'd0);
    check({name, "_rd_be"},   32'(rd_be_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'hC0DE0000 + 32'(i);
    mem[4] = 32'hDEADBEEF;
    mem[0] = 32'h11112222;
    rst_n = 1'b0; req_compl_i = 1'b0; req_compl_with_data_i = 1'b0; req_tc_i = '0;
    req_td_i = 1'b0; req_ep_i = 1'b0; req_attr_i = '0; req_len_i = '0; req_rid_i = 16'h0100;
    req_tag_i = '0; req_be_i = '0; req_addr_i = '0; cfg_completer_id_i = 16'h0200;
    trn_tdst_rdy_n_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // CplD single DW
    request(1'b1, 10'd1, 8'h0F, 13'h0010, 8'h05, 3'd0, 2'd0, 1'b0);
    check("t1_hdr_start_sof", 32'(trn_tsof_n_o), 32'd0);
    collect(1'b0, 1'b0);
    exp_td[0] = 32'h4A000001; exp_td[1] = 32'h02000004;
    exp_td[2] = 32'h01000510; exp_td[3] = 32'hDEADBEEF;
    check("t1_cycles", 32'(cyc_used), 32'd4);
    verify("t1", 4);

    // Cpl without data
    request(1'b0, 10'd1, 8'h0F, 13'h0010, 8'h06, 3'd0, 2'd0, 1'b0);
    collect(1'b0, 1'b0);
    exp_td[0] = 32'h0A000000; exp_td[1] = 32'h02000004; exp_td[2] = 32'h01000610;
    verify("t2", 3);
    check("t2_no_read_addr", 32'(rd_addr_o), 32'd4);
    check("t2_no_read_be", 32'(rd_be_o), 32'hF);

    // Byte count / lower address, single DW
    request(1'b1, 10'd1, 8'h06, 13'h0000, 8'h07, 3'd0, 2'd0, 1'b0);
    collect(1'b0, 1'b0);
    exp_td[0] = 32'h4A000001; exp_td[1] = 32'h02000002;
    exp_td[2] = 32'h01000701; exp_td[3] = mem[0];
    verify("t3a", 4);

    // Byte count, len=4, first BE E, last BE 3
    request(1'b1, 10'd4, 8'h3E, 13'h0100, 8'h08, 3'd0, 2'd0, 1'b0);
    collect(1'b0, 1'b0);
    exp_td[0] = 32'h4A000004; exp_td[1] = 32'h0200000D; exp_td[2] = 32'h01000801;
    for (int i = 0; i < 4; i++) exp_td[3+i] = mem[64+i];
    check("t3b_cycles", 32'(cyc_used), 32'd7);
    check("t3b_last_be", 32'(rd_be_o), 32'h3);
    verify("t3b", 7);

    // Backpressure, len=8, with TC/attr/TD set
    request(1'b1, 10'd8, 8'hFF, 13'h0200, 8'h09, 3'b101, 2'b10, 1'b1);
    collect(1'b1, 1'b0);
    exp_td[0] = 32'h4A50A008; exp_td[1] = 32'h02000020; exp_td[2] = 32'h01000900;
    for (int i = 0; i < 8; i++) exp_td[3+i] = mem[128+i];
    verify("t4", 11);

    // Address wrap and busy drop
    request(1'b1, 10'd4, 8'hFF, 13'h1FF8, 8'h0A, 3'd0, 2'd0, 1'b0);
    collect(1'b0, 1'b1);
    exp_td[0] = 32'h4A000004; exp_td[1] = 32'h02000010; exp_td[2] = 32'h01000A78;
    for (int i = 0; i < 4; i++) exp_td[3+i] = mem[11'(2046 + i)];
    verify("t5", 7);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!trn_tsrc_rdy_n_o || !trn_tsof_n_o || compl_done_o) extra++;
    end
    check("t5_busy_drop", 32'(extra), 32'd0);
    check("t5_wrap_addr", 32'(rd_addr_o), 32'd1);

    // Reset mid-DATA, then a clean completion
    request(1'b1, 10'd8, 8'hFF, 13'h0400, 8'h0C, 3'd0, 2'd0, 1'b0);
    repeat (4) @(negedge clk);
    check("t6_mid_data", 32'(trn_tsrc_rdy_n_o), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("t6_reset");
    rst_n = 1'b1;
    request(1'b1, 10'd2, 8'hFF, 13'h0410, 8'h0B, 3'd0, 2'd0, 1'b0);
    collect(1'b0, 1'b0);
    exp_td[0] = 32'h4A000002; exp_td[1] = 32'h02000008; exp_td[2] = 32'h01000B10;
    exp_td[3] = mem[260]; exp_td[4] = mem[261];
    verify("t6", 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
